// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared constants, types and busy priority helper for the register file
package regfile_pkg;

  localparam int DW_DEF  = 32;
  localparam int AW_DEF  = 5;
  localparam int NRD_DEF = 2;

  typedef logic [(2**AW_DEF)-1:0] busy_vec_t;

  // Busy next state: squash beats issue, issue beats a same-cycle writeback clear.
  function automatic logic busy_next(input logic cur, input logic flush,
                                     input logic iss_hit, input logic wr_hit);
    if (flush)   return 1'b0;
    if (iss_hit) return 1'b1;
    if (wr_hit)  return 1'b0;
    return cur;
  endfunction

endpackage

// File: rtl/regfile_busy_tracker.sv
// rtl/regfile_busy_tracker.sv - per-register pending-write bits, pending count and hazard flags
module regfile_busy_tracker
  import regfile_pkg::*;
#(
  parameter int AW     = AW_DEF,
  parameter int NRD    = NRD_DEF,
  parameter int BYPASS = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NRD*AW-1:0] rd_addr,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic             iss_en,
  input  logic [AW-1:0]    iss_addr,
  input  logic             flush,
  output logic [NRD-1:0]   rd_busy,
  output logic             iss_waw,
  output logic [AW:0]      pend_cnt
);

  localparam int DEPTH = 1 << AW;

  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] busy_d;
  logic             inc;
  logic             dec;
  logic             iss_valid;
  logic             wr_valid;

  assign iss_valid = iss_en && (iss_addr != '0);
  assign wr_valid  = wr_en && (wr_addr != '0);

  // Register 0 never goes busy; every other bit follows the priority helper.
  always_comb begin
    busy_d = '0;
    for (int i = 1; i < DEPTH; i++) begin
      busy_d[i] = busy_next(busy[i], flush,
                            iss_en && (iss_addr == AW'(i)),
                            wr_en && (wr_addr == AW'(i)));
    end
  end

  // Count tracks the popcount: an issue adds only to an idle register, and a
  // clear subtracts only when the same register is not re-issued this cycle.
  assign inc = iss_valid && !busy[iss_addr];
  assign dec = wr_valid && busy[wr_addr] && !(iss_en && (iss_addr == wr_addr));

  assign iss_waw = iss_valid && busy[iss_addr] && !(wr_en && (wr_addr == iss_addr));

  for (genvar p = 0; p < NRD; p++) begin : g_port
    logic [AW-1:0] a;
    assign a = rd_addr[p*AW +: AW];
    assign rd_busy[p] = busy[a] && !((BYPASS != 0) && wr_en && (wr_addr == a));
  end

  // Busy vector and pending count state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy     <= '0;
      pend_cnt <= '0;
    end else begin
      busy <= busy_d;
      if (flush) pend_cnt <= '0;
      else       pend_cnt <= pend_cnt + {{AW{1'b0}}, inc} - {{AW{1'b0}}, dec};
    end
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - register file with zero register, write bypass and scoreboard
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int DW     = DW_DEF,
  parameter int AW     = AW_DEF,
  parameter int NRD    = NRD_DEF,
  parameter int BYPASS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD*DW-1:0] rd_data,
  output logic [NRD-1:0]    rd_busy,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DW-1:0]     wr_data,
  input  logic              iss_en,
  input  logic [AW-1:0]     iss_addr,
  output logic              iss_waw,
  input  logic              flush,
  output logic [AW:0]       pend_cnt
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem [DEPTH];

  // Data array; flush does not gate writeback, and address 0 is never stored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en && (wr_addr != '0)) begin
      mem[wr_addr] <= wr_data;
    end
  end

  for (genvar p = 0; p < NRD; p++) begin : g_read
    logic [AW-1:0] a;
    assign a = rd_addr[p*AW +: AW];
    assign rd_data[p*DW +: DW] =
      (a == '0) ? '0 :
      ((BYPASS != 0) && wr_en && (wr_addr == a)) ? wr_data : mem[a];
  end

  regfile_busy_tracker #(
    .AW     (AW),
    .NRD    (NRD),
    .BYPASS (BYPASS)
  ) u_busy (
    .clk      (clk),
    .rst      (rst),
    .rd_addr  (rd_addr),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .flush    (flush),
    .rd_busy  (rd_busy),
    .iss_waw  (iss_waw),
    .pend_cnt (pend_cnt)
  );

endmodule
